// File: rtl/issue_ctrl.sv
// Decode/issue sequencer: one-entry decode slot plus an issue register, with a register scoreboard and redirect squash.
// Latency: a beat accepted at edge N with no hazard and a free execute stage is presented on out_* after edge N+1.
// Backpressure: in_ready combinationally follows out_ready and hazards; the issue register holds while !out_ready.
module issue_ctrl #(
  parameter int FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        redirect,
  output logic [31:0] scoreboard,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  // Register-usage summary of one opcode.
  typedef struct packed {
    logic illegal;
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: d.writes_rd = 1'b1;   // LUI, AUIPC, JAL
      7'b1100111, 7'b0000011, 7'b0010011: begin                 // JALR, LOAD, OP-IMM
        d.uses_rs1  = 1'b1;
        d.writes_rd = 1'b1;
      end
      7'b1100011, 7'b0100011: begin                             // BRANCH, STORE
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      7'b0110011: begin                                         // OP
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.writes_rd = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Registered state
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_illegal_q, out_illegal_d;
  logic [31:0] sb_q, sb_d;
  logic [31:0] stall_q, stall_d;

  // Combinational decode of slot and issue register
  dec_t        d_dec, o_dec;
  logic [4:0]  d_rs1, d_rs2, d_rd, o_rd;
  logic        hz_rs1, hz_rs2, hz_rd, hazard;
  logic        issue, in_rdy, accept_run, drop_beat, out_hs;
  logic [31:0] sb_set, sb_clr;

  assign d_dec = decode(d_instr_q[6:0]);
  assign o_dec = decode(out_instr_q[6:0]);
  assign d_rs1 = d_instr_q[19:15];
  assign d_rs2 = d_instr_q[24:20];
  assign d_rd  = d_instr_q[11:7];
  assign o_rd  = out_instr_q[11:7];

  // Hazard: any register the slot touches is busy or about to be written by the issue register.
  always_comb begin
    hz_rs1 = 1'b0;
    hz_rs2 = 1'b0;
    hz_rd  = 1'b0;
    if (d_dec.uses_rs1 && (d_rs1 != 5'd0))
      hz_rs1 = sb_q[d_rs1] || (out_valid_q && o_dec.writes_rd && (o_rd == d_rs1));
    if (d_dec.uses_rs2 && (d_rs2 != 5'd0))
      hz_rs2 = sb_q[d_rs2] || (out_valid_q && o_dec.writes_rd && (o_rd == d_rs2));
    if (d_dec.writes_rd && (d_rd != 5'd0))
      hz_rd = sb_q[d_rd] || (out_valid_q && o_dec.writes_rd && (o_rd == d_rd));
    hazard = d_valid_q && (hz_rs1 || hz_rs2 || hz_rd);
  end

  // Handshake terms; in DROP every beat is swallowed, and nothing is accepted on a redirect or in reset.
  always_comb begin
    issue      = d_valid_q && !hazard && (!out_valid_q || out_ready) && !redirect;
    in_rdy     = !rst && !redirect && ((state_q == ST_DROP) || !d_valid_q || issue);
    accept_run = in_valid && in_rdy && (state_q == ST_RUN);
    drop_beat  = in_valid && in_rdy && (state_q == ST_DROP);
    out_hs     = out_valid_q && out_ready && !redirect;
  end

  // Decode slot and issue register next state; redirect squashes both.
  always_comb begin
    d_valid_d     = d_valid_q;
    d_instr_d     = d_instr_q;
    d_pc_d        = d_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_illegal_d = out_illegal_q;
    if (redirect) begin
      d_valid_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (issue) begin
        out_valid_d   = 1'b1;
        out_instr_d   = d_instr_q;
        out_pc_d      = d_pc_q;
        out_illegal_d = d_dec.illegal;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept_run) begin
        d_valid_d = 1'b1;
        d_instr_d = in_instr;
        d_pc_d    = in_pc;
      end else if (issue) begin
        d_valid_d = 1'b0;
      end
    end
  end

  // Scoreboard: mark on execute handshake, release on writeback; a same-cycle mark wins.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (out_hs && o_dec.writes_rd && (o_rd != 5'd0))
      sb_set[o_rd] = 1'b1;
    if (wb_valid)
      sb_clr[wb_rd] = 1'b1;
    sb_d    = (sb_q & ~sb_clr) | sb_set;
    sb_d[0] = 1'b0;
  end

  // Saturating count of cycles the slot sits blocked on a hazard.
  always_comb begin
    stall_d = stall_q;
    if (hazard && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stale-beat drop sequencing after a redirect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      cnt_d   = FLUSH_CNT;
      state_d = (FLUSH_CNT == 4'd0) ? ST_RUN : ST_DROP;
    end else if (state_q == ST_DROP) begin
      if (cnt_q == 4'd0) begin
        state_d = ST_RUN;
      end else if (drop_beat) begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = ST_RUN;
      end
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= 4'd0;
      d_valid_q     <= 1'b0;
      d_instr_q     <= 32'd0;
      d_pc_q        <= 32'd0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'd0;
      out_pc_q      <= 32'd0;
      out_illegal_q <= 1'b0;
      sb_q          <= 32'd0;
      stall_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      d_valid_q     <= d_valid_d;
      d_instr_q     <= d_instr_d;
      d_pc_q        <= d_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_illegal_q <= out_illegal_d;
      sb_q          <= sb_d;
      stall_q       <= stall_d;
    end
  end

  assign in_ready     = in_rdy;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_illegal  = out_illegal_q;
  assign scoreboard   = sb_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus a randomized run.
// Expected issue stream and busy vector come from a transaction-level model kept here.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_issue_ctrl;

  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        redirect = 1'b0;
  logic [31:0] scoreboard;
  logic [31:0] stall_cycles;

  issue_ctrl #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect(redirect),
    .scoreboard(scoreboard), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        illegal;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] busy_m = '0;
  int          drop_left = 0;
  txn_t        t;
  logic [31:0] set_m, clr_m;

  function automatic logic writes_rd(input logic [31:0] ins);
    return ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  endfunction
  function automatic logic reads_rs1(input logic [31:0] ins);
    return ins[6:0] inside {7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};
  endfunction
  function automatic logic reads_rs2(input logic [31:0] ins);
    return ins[6:0] inside {7'h63, 7'h23, 7'h33};
  endfunction
  function automatic logic legal(input logic [31:0] ins);
    return writes_rd(ins) || reads_rs1(ins) || reads_rs2(ins);
  endfunction
  function automatic logic [31:0] bit_of(input logic [4:0] r);
    logic [31:0] m;
    m = (32'd1 << r);
    m[0] = 1'b0;
    return m;
  endfunction
  function automatic logic [31:0] write_mask(input logic [31:0] ins);
    return writes_rd(ins) ? bit_of(ins[11:7]) : 32'd0;
  endfunction
  function automatic logic [31:0] touch_mask(input logic [31:0] ins);
    logic [31:0] m;
    m = write_mask(ins);
    if (reads_rs1(ins)) m = m | bit_of(ins[19:15]);
    if (reads_rs2(ins)) m = m | bit_of(ins[24:20]);
    return m;
  endfunction

  // Monitor: judges each cycle's handshakes just before the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_in_ready", in_ready, 0);
      exp_q.delete();
      busy_m    = '0;
      drop_left = 0;
    end else begin
      check("scoreboard", scoreboard, busy_m);
      clr_m = wb_valid ? bit_of(wb_rd) : 32'd0;
      set_m = '0;
      if (redirect) begin
        check("redirect_in_ready", in_ready, 0);
        exp_q.delete();
        drop_left = FD;
      end else begin
        if (out_valid && out_ready) begin
          check("issue_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            check("issue_instr", out_instr, t.instr);
            check("issue_pc", out_pc, t.pc);
            check("issue_illegal", out_illegal, t.illegal);
            check("issue_hazard_free", touch_mask(t.instr) & busy_m, 0);
            set_m = write_mask(t.instr);
          end
        end
        if (in_valid) begin
          if (drop_left > 0) begin
            check("drop_in_ready", in_ready, 1);
            if (in_ready) drop_left--;
          end else if (in_ready) begin
            t.instr   = in_instr;
            t.pc      = in_pc;
            t.illegal = !legal(in_instr);
            exp_q.push_back(t);
          end
        end
      end
      busy_m = (busy_m & ~clr_m) | set_m;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called 1 unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [4:0] rs1, rs2, rd;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h7F};
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    return {7'd0, rs2, rs1, 3'd0, rd, ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_scoreboard", scoreboard, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // Back-to-back independent issue
    out_ready = 1'b1;
    send(32'h00100093, 32'h100);
    send(32'h00200113, 32'h104);
    @(negedge clk);
    check("t1_first_valid", out_valid, 1);
    check("t1_first_instr", out_instr, 32'h00100093);
    @(negedge clk);
    check("t1_second_valid", out_valid, 1);
    check("t1_second_instr", out_instr, 32'h00200113);
    @(negedge clk);
    check("t1_scoreboard", scoreboard, 32'h6);

    // RAW stall released by writeback
    do_reset();
    send(32'h00100093, 32'h200);
    send(32'h001081B3, 32'h204);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("t2_stall_count", stall_cycles, k);
    end
    check("t2_add_held", out_valid, 0);
    @(posedge clk); #1;
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    check("t2_not_yet", out_valid, 0);
    check("t2_stall_final", stall_cycles, 6);
    @(negedge clk);
    check("t2_add_valid", out_valid, 1);
    check("t2_add_instr", out_instr, 32'h001081B3);
    check("t2_stall_frozen", stall_cycles, 6);

    // x0 writers never stall or mark busy
    do_reset();
    for (int i = 0; i < 6; i++) send(32'h00000013, 32'h300 + 32'(i * 4));
    repeat (2) begin
      @(negedge clk);
      check("t3_stall", stall_cycles, 0);
      check("t3_scoreboard", scoreboard, 0);
    end

    // Redirect with slot and issue register both full
    do_reset();
    out_ready = 1'b0;
    send(32'h00100093, 32'h400);
    send(32'h00200113, 32'h404);
    redirect = 1'b1;
    @(posedge clk); #1;
    redirect  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t4_squashed", out_valid, 0);
    check("t4_drop_ready", in_ready, 1);
    send(32'h00300193, 32'h408);
    send(32'h00400213, 32'h40C);
    send(32'h00500293, 32'h410);
    @(negedge clk);
    check("t4_third_pending", out_valid, 0);
    @(negedge clk);
    check("t4_third_valid", out_valid, 1);
    check("t4_third_instr", out_instr, 32'h00500293);
    check("t4_third_pc", out_pc, 32'h410);
    check("t4_sb_clean", scoreboard, 0);

    // Illegal opcode, then same-cycle set/clear
    do_reset();
    send(32'h000000FF, 32'h500);
    @(negedge clk);
    check("t5_ill_pending", out_valid, 0);
    @(negedge clk);
    check("t5_ill_valid", out_valid, 1);
    check("t5_ill_flag", out_illegal, 1);
    @(negedge clk);
    check("t5_ill_no_busy", scoreboard, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00600313, 32'h504);
    @(posedge clk); #1;
    check("t5_held", out_valid, 1);
    check("t5_held_instr", out_instr, 32'h00600313);
    out_ready = 1'b1;
    wb_valid  = 1'b1;
    wb_rd     = 5'd6;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    check("t5_set_wins", scoreboard, 32'h40);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'h00700393, 32'h508);
    @(posedge clk); #1;
    check("t6_pre_valid", out_valid, 1);
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_instr", out_instr, 0);
    check("t6_out_pc", out_pc, 0);
    check("t6_scoreboard", scoreboard, 0);
    check("t6_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("t6_in_ready_held", in_ready, 0);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Randomized traffic
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      in_pc     = 32'h1000 + 32'(c * 4);
      out_ready = ($urandom_range(0, 9) < 8);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_rd     = 5'($urandom_range(0, 7));
      redirect  = ($urandom_range(0, 99) < 3);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      wb_valid = 1'b1;
      wb_rd    = 5'(c % 8);
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    @(negedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 0);
    check("drain_out_idle", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
